// File: rtl/poly_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly_shift_pkg
// Description : Shared types and constants for the POKEY serial/poly shift
//               engine (FSM state encoding, default 8-bit poly taps and the
//               bit-counter width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package poly_shift_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Default feedback taps for the 8-bit poly counter
    localparam logic [7:0] POLY8_TAPS = 8'hB8;

    // Bits needed to hold a count from 0 up to and including width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : poly_shift_pkg
`default_nettype wire

// File: rtl/poly_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : poly_shift_ctrl
// Description : Transfer sequencer for poly_shift_reg. IDLE/SHIFT/DONE FSM
//               plus a down-counting bit counter; produces the datapath
//               load/shift strobes and the busy/done flags. Every state
//               change is qualified by the enp slow-clock strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_shift_ctrl
    import poly_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enp,
    input  logic start,
    input  logic load,
    input  logic fb_run,     // free-running poly shift requested while idle
    output logic shift_en,
    output logic load_en,
    output logic busy,
    output logic done
);

    localparam int                   c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0]   c_cnt_full = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

    // State and bit-counter registers; next values already hold when enp=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and strobe decode; start beats load beats shift/hold
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        shift_en    = 1'b0;
        load_en     = 1'b0;
        if (enp) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        load_en     = 1'b1;
                        w_cnt_nxt   = c_cnt_full;
                        w_state_nxt = ST_SHIFT;
                    end else if (load) begin
                        load_en     = 1'b1;
                    end else if (fb_run) begin
                        shift_en    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // start/load are ignored until the transfer finishes
                    shift_en  = 1'b1;
                    w_cnt_nxt = r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        // Back-to-back transfer with no idle gap
                        load_en     = 1'b1;
                        w_cnt_nxt   = c_cnt_full;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        load_en     = load;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

endmodule : poly_shift_ctrl
`default_nettype wire

// File: rtl/poly_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : poly_shift_reg
// Description : WIDTH-bit serial shift engine for the POKEY serial/poly
//               datapath. Parallel load, selectable shift direction, and a
//               start/busy/done transfer sequence, all qualified by enp.
//               Optional macro POLY_SHIFT_FB_EN enables LFSR feedback
//               (TAP_MASK) and free-running poly mode while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_shift_reg
    import poly_shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               MSB_FIRST = 0,
    parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(POLY8_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enp,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             sin,
    input  logic             fb_en,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_shift;
    logic             w_sin_eff;
    logic             w_fb_run;
    logic             w_shift_en;
    logic             w_load_en;

`ifdef POLY_SHIFT_FB_EN
    // Tapped parity folded into the incoming bit whenever feedback is on
    assign w_sin_eff = sin ^ (fb_en & (^(r_q & TAP_MASK)));
    assign w_fb_run  = fb_en;
`else
    // Feedback absent: fb_en and the tap mask are deliberately left dangling
    logic             w_unused_fb;
    localparam logic [WIDTH-1:0] c_unused_taps = TAP_MASK;
    assign w_unused_fb = fb_en ^ (^c_unused_taps);
    assign w_sin_eff   = sin;
    assign w_fb_run    = 1'b0;
`endif

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_q_shift = {r_q[WIDTH-2:0], w_sin_eff};
            assign sout      = r_q[WIDTH-1];
        end else begin : g_lsb_first
            assign w_q_shift = {w_sin_eff, r_q[WIDTH-1:1]};
            assign sout      = r_q[0];
        end
    endgenerate

    poly_shift_ctrl #(
        .WIDTH    (WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .enp      (enp),
        .start    (start),
        .load     (load),
        .fb_run   (w_fb_run),
        .shift_en (w_shift_en),
        .load_en  (w_load_en),
        .busy     (busy),
        .done     (done)
    );

    // Shift register: parallel load wins over shifting; strobes already carry enp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (w_load_en) begin
            r_q <= ld_data;
        end else if (w_shift_en) begin
            r_q <= w_q_shift;
        end
    end

    assign q = r_q;

endmodule : poly_shift_reg
`default_nettype wire
